// File: rtl/loader_pkg.sv
// Shared types and constants for the byte-stream program loader.
// Build option: PROGRAM_LOADER_CHECKSUM_EN adds the trailing XOR checksum byte and its CSUM state.
package loader_pkg;

    localparam int LOADER_LEN_BYTES = 2;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        WRITE,
        CSUM,
        DONE,
        ERROR
    } loader_state_t;
`else
    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        WRITE,
        DONE,
        ERROR
    } loader_state_t;
`endif

    // Instruction words travel as whole bytes; pad bits above the word are dropped.
    function automatic int bytes_per_word(input int iw);
        return (iw + 7) / 8;
    endfunction

    function automatic logic state_takes_bytes(input loader_state_t s);
        logic takes;
        takes = 1'b0;
        case (s)
            LEN_HI, LEN_LO, DATA: takes = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            CSUM: takes = 1'b1;
`endif
            default: takes = 1'b0;
        endcase
        return takes;
    endfunction

endpackage

// File: rtl/loader_word_assembler.sv
// Shifts incoming bytes MSB-first into an instruction word and flags the byte that completes it.
// The word output already includes the byte being presented, so it is valid in the completing cycle.
module loader_word_assembler #(
    parameter int IW = 10,
    parameter int B  = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          byte_valid,
    input  logic [7:0]    byte_in,
    output logic [IW-1:0] word,
    output logic          word_done
);

    localparam int            CW   = (B > 1) ? $clog2(B) : 1;
    localparam logic [CW-1:0] LAST = CW'(B - 1);

    logic [IW-1:0] shreg;
    logic [CW-1:0] count;

    assign word      = IW'({shreg, byte_in});
    assign word_done = byte_valid && (count == LAST);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            shreg <= '0;
            count <= '0;
        end else if (byte_valid) begin
            shreg <= word;
            count <= word_done ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/program_loader.sv
// Receives a length-prefixed program over a byte handshake and writes it into instruction memory.
// Build option: PROGRAM_LOADER_CHECKSUM_EN requires a trailing XOR checksum byte before DONE.
module program_loader
    import loader_pkg::*;
#(
    parameter int M = 3,
    parameter int P = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    input  logic               reload,
    output logic               imem_write_en,
    output logic [P-1:0]       imem_write_addr,
    output logic [4+2*M-1:0]   imem_write_data,
    output logic               cpu_hold,
    output logic               load_done,
    output logic               load_error
);

    localparam int IW    = 4 + 2 * M;
    localparam int B     = bytes_per_word(IW);
    localparam int LEN_W = 8 * LOADER_LEN_BYTES;
    localparam logic [LEN_W:0] LEN_MAX = {{LEN_W{1'b0}}, 1'b1} << P;

    loader_state_t state;
    loader_state_t next_state;

    logic             accept;
    logic [7:0]       len_hi;
    logic [LEN_W-1:0] frame_len;
    logic             len_bad;
    logic [P:0]       len;
    logic [P:0]       idx;
    logic [P:0]       idx_inc;

    logic             asm_clear;
    logic             asm_valid;
    logic             asm_done;
    logic [IW-1:0]    asm_word;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]       csum;
`endif

    assign accept    = rx_valid && rx_ready;
    assign frame_len = {len_hi, rx_data};
    assign len_bad   = (frame_len == '0) || ({1'b0, frame_len} > LEN_MAX);
    // One extra bit so a full 2^P-instruction program ends without wrapping.
    assign idx_inc   = idx + (P+1)'(1);
    assign asm_valid = accept && (state == DATA);
    assign asm_clear = (state == IDLE);

    loader_word_assembler #(
        .IW (IW),
        .B  (B)
    ) u_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (asm_clear),
        .byte_valid (asm_valid),
        .byte_in    (rx_data),
        .word       (asm_word),
        .word_done  (asm_done)
    );

    always_comb begin
        next_state = state;
        case (state)
            IDLE:   next_state = LEN_HI;
            LEN_HI: if (accept) next_state = LEN_LO;
            LEN_LO: if (accept) next_state = len_bad ? ERROR : DATA;
            DATA:   if (asm_done) next_state = WRITE;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            WRITE:  next_state = (idx_inc < len) ? DATA : CSUM;
            CSUM:   if (accept) next_state = (rx_data == csum) ? DONE : ERROR;
`else
            WRITE:  next_state = (idx_inc < len) ? DATA : DONE;
`endif
            DONE,
            ERROR:  if (reload) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are registered from the upcoming state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            len_hi          <= '0;
            len             <= '0;
            idx             <= '0;
            rx_ready        <= 1'b0;
            imem_write_en   <= 1'b0;
            imem_write_addr <= '0;
            imem_write_data <= '0;
            cpu_hold        <= 1'b1;
            load_done       <= 1'b0;
            load_error      <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum            <= '0;
`endif
        end else begin
            state         <= next_state;
            rx_ready      <= state_takes_bytes(next_state);
            imem_write_en <= (next_state == WRITE);
            cpu_hold      <= (next_state != DONE);
            load_done     <= (next_state == DONE);
            load_error    <= (next_state == ERROR);

            if (state == LEN_HI && accept) begin
                len_hi <= rx_data;
            end
            if (state == LEN_LO && accept) begin
                len <= (P+1)'({1'b0, frame_len});
            end
            if (next_state == WRITE) begin
                imem_write_addr <= idx[P-1:0];
                imem_write_data <= asm_word;
            end

            if (state == IDLE) begin
                idx <= '0;
            end else if (state == WRITE) begin
                idx <= idx_inc;
            end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
            if (state == IDLE) begin
                csum <= '0;
            end else if (accept && (state == LEN_HI || state == LEN_LO || state == DATA)) begin
                csum <= csum ^ rx_data;
            end
`endif
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader (M=3, P=4): a frame-level model predicts writes and final status.
// Frames carry a checksum byte only when PROGRAM_LOADER_CHECKSUM_EN is defined.
module tb_program_loader;

    localparam int M  = 3;
    localparam int P  = 4;
    localparam int IW = 4 + 2 * M;

    typedef logic [7:0] byte_t;
    typedef struct {
        logic [P-1:0]  addr;
        logic [IW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          reload;
    logic          imem_write_en;
    logic [P-1:0]  imem_write_addr;
    logic [IW-1:0] imem_write_data;
    logic          cpu_hold;
    logic          load_done;
    logic          load_error;

    int  checks = 0;
    int  passes = 0;
    wr_t exp_q[$];
    wr_t log_q[$];
    bit  exp_done;
    bit  exp_error;

    always #5 clk = ~clk;

    program_loader #(.M(M), .P(P)) dut (
        .clk             (clk),
        .rst             (rst),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .rx_ready        (rx_ready),
        .reload          (reload),
        .imem_write_en   (imem_write_en),
        .imem_write_addr (imem_write_addr),
        .imem_write_data (imem_write_data),
        .cpu_hold        (cpu_hold),
        .load_done       (load_done),
        .load_error      (load_error)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    endtask

    // Frame-level model: length rule, big-endian words truncated to IW, XOR over all preceding bytes.
    function automatic void buildModel(input byte_t frame[$]);
        int          len;
        logic [15:0] w;
        byte_t       x;
        wr_t         e;
        exp_q.delete();
        len = {frame[0], frame[1]};
        if (len == 0 || len > (1 << P)) begin
            exp_done  = 1'b0;
            exp_error = 1'b1;
            return;
        end
        for (int i = 0; i < len; i++) begin
            w      = {frame[2 + 2*i], frame[3 + 2*i]};
            e.addr = P'(i);
            e.data = w[IW-1:0];
            exp_q.push_back(e);
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        x = 8'h00;
        for (int i = 0; i < 2 + 2*len; i++) x = x ^ frame[i];
        exp_done  = (frame[2 + 2*len] == x);
        exp_error = !exp_done;
`else
        x = 8'h00;
        exp_done  = 1'b1;
        exp_error = (x != 8'h00);
`endif
    endfunction

    // Every write the DUT issues is checked in order against the model.
    always @(negedge clk) begin
        wr_t e;
        if (!rst && imem_write_en) begin
            e.addr = imem_write_addr;
            e.data = imem_write_data;
            log_q.push_back(e);
            if (exp_q.size() == 0) begin
                checks++;
                $display("[TB] FAIL unexpected_write: got addr=%0d data=0x%0h, want no write",
                         imem_write_addr, imem_write_data);
            end else begin
                e = exp_q.pop_front();
                checkOutput("write_addr", 32'(imem_write_addr), 32'(e.addr));
                checkOutput("write_data", 32'(imem_write_data), 32'(e.data));
                checkOutput("ready_in_write", 32'(rx_ready), 32'd0);
            end
        end
    end

    task automatic sendByte(input byte_t b, input bit hold_valid);
        int n;
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!rx_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!rx_ready) begin
            checks++;
            $display("[TB] FAIL ready_timeout: got rx_ready=0 for 200 cycles, want 1");
        end
        @(posedge clk);
        #1;
        if (!hold_valid) begin
            rx_valid = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input byte_t frame[$], input bit hold_valid, input string name);
        int n;
        buildModel(frame);
        log_q.delete();
        foreach (frame[i]) sendByte(frame[i], hold_valid);
        rx_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!(load_done || load_error) && n < 100) begin
            n++;
            @(negedge clk);
        end
        checkOutput({name, "_done"},       32'(load_done),    32'(exp_done));
        checkOutput({name, "_error"},      32'(load_error),   32'(exp_error));
        checkOutput({name, "_hold"},       32'(cpu_hold),     32'(!exp_done));
        checkOutput({name, "_ready"},      32'(rx_ready),     32'd0);
        checkOutput({name, "_writes_left"}, 32'(exp_q.size()), 32'd0);
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
    endtask

    // Hand-computed result of the three-instruction reference frame.
    task automatic checkLog(input string name);
        checkOutput({name, "_count"}, 32'(log_q.size()), 32'd3);
        if (log_q.size() >= 3) begin
            checkOutput({name, "_a0"}, 32'(log_q[0].addr), 32'd0);
            checkOutput({name, "_d0"}, 32'(log_q[0].data), 32'h123);
            checkOutput({name, "_a1"}, 32'(log_q[1].addr), 32'd1);
            checkOutput({name, "_d1"}, 32'(log_q[1].data), 32'h245);
            checkOutput({name, "_a2"}, 32'(log_q[2].addr), 32'd2);
            checkOutput({name, "_d2"}, 32'(log_q[2].data), 32'h3FF);
        end
    endtask

    task automatic checkResetValues(input string name);
        checkOutput({name, "_ready"}, 32'(rx_ready),        32'd0);
        checkOutput({name, "_wen"},   32'(imem_write_en),   32'd0);
        checkOutput({name, "_waddr"}, 32'(imem_write_addr), 32'd0);
        checkOutput({name, "_wdata"}, 32'(imem_write_data), 32'd0);
        checkOutput({name, "_hold"},  32'(cpu_hold),        32'd1);
        checkOutput({name, "_done"},  32'(load_done),       32'd0);
        checkOutput({name, "_error"}, 32'(load_error),      32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running, want finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        byte_t frame_a[$];
        byte_t frame_bad[$];
        byte_t frame_len0[$];
        byte_t frame_len17[$];
        byte_t frame_full[$];
        int    n;

        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        reload   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetValues("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        frame_a = '{8'h00, 8'h03, 8'h01, 8'h23, 8'h02, 8'h45, 8'h03, 8'hFF};
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        // XOR of the eight frame bytes above is 0x9A.
        frame_a.push_back(8'h9A);
`endif
        applyStimulus(frame_a, 1'b0, "frame_a");
        checkLog("frame_a");

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        frame_bad = '{8'h00, 8'h03, 8'h01, 8'h23, 8'h02, 8'h45, 8'h03, 8'hFF, 8'h00};
        applyStimulus(frame_bad, 1'b0, "cs_zero");
        checkLog("cs_zero");
        frame_bad[8] = 8'h9F;
        applyStimulus(frame_bad, 1'b0, "cs_9f");
        checkLog("cs_9f");
`endif

        frame_len0 = '{8'h00, 8'h00};
        applyStimulus(frame_len0, 1'b0, "len0");
        checkOutput("len0_count", 32'(log_q.size()), 32'd0);

        frame_len17 = '{8'h00, 8'h11};
        applyStimulus(frame_len17, 1'b0, "len17");
        checkOutput("len17_count", 32'(log_q.size()), 32'd0);

        applyStimulus(frame_a, 1'b1, "stream");
        checkLog("stream");

        // Reset after the first write has gone out, then resend the whole frame.
        buildModel(frame_a);
        log_q.delete();
        for (int i = 0; i < 4; i++) sendByte(frame_a[i], 1'b0);
        n = 0;
        while (log_q.size() < 1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        checkOutput("rst_first_write", 32'(log_q.size()), 32'd1);
        rst = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkResetValues("rst_mid");
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(frame_a, 1'b0, "after_rst");
        checkLog("after_rst");

        // Reset on the very edge that would complete an instruction: no write may follow.
        exp_q.delete();
        log_q.delete();
        for (int i = 0; i < 3; i++) sendByte(frame_a[i], 1'b0);
        rx_data  = frame_a[3];
        rx_valid = 1'b1;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkResetValues("rst_write");
        checkOutput("rst_write_none", 32'(log_q.size()), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        frame_full = '{8'h00, 8'h10};
        for (int i = 0; i < 32; i++) frame_full.push_back(8'hFF);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        // The 32 0xFF bytes cancel, leaving 0x00 ^ 0x10.
        frame_full.push_back(8'h10);
`endif
        applyStimulus(frame_full, 1'b1, "full16");
        checkOutput("full16_count", 32'(log_q.size()), 32'd16);
        if (log_q.size() == 16) begin
            checkOutput("full16_first_addr", 32'(log_q[0].addr),  32'd0);
            checkOutput("full16_last_addr",  32'(log_q[15].addr), 32'd15);
            checkOutput("full16_last_data",  32'(log_q[15].data), 32'h3FF);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
